// File: rtl/btn_conditioner_if.sv
// Button bundle between the pins, the conditioner and the button-state consumers.
// master: the conditioner (takes raw pins, drives clean state); slave: pin driver / consumer side.
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_repeat
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchroniser, counter debounce, press/release pulses and auto-repeat.
// Define BTN_REPEAT_EN to build the auto-repeat FSMs; otherwise btn_repeat is tied low.
module btn_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 30000000,
  parameter int unsigned REPEAT_RATE     = 10000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic          clk,
  input  logic          rst,
  btn_conditioner_if.master btn
);

  localparam int unsigned MAX_CYC_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC   = (MAX_CYC_A > REPEAT_RATE) ? MAX_CYC_A : REPEAT_RATE;

  // Reject parameter sets the counters cannot represent.
  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2 ||
        (CNT_W < 32 && 64'(MAX_CYC) >= (64'd1 << CNT_W))) begin : g_bad_params
      $error("btn_conditioner: illegal cycle-count parameters for CNT_W");
    end
  endgenerate

`ifdef BTN_REPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;
`endif

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn.btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic             stable_q;
    logic             press_q;
    logic             release_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic             flip_c;
    logic             press_c;
    logic             release_c;

    // Stable value flips once the synchronised input has disagreed long enough.
    assign flip_c    = (sync2[i] != stable_q) && (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press_c   = flip_c &  sync2[i];
    assign release_c = flip_c & ~sync2[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        db_cnt_q  <= '0;
      end else begin
        press_q   <= press_c;
        release_q <= release_c;
        if (sync2[i] == stable_q) begin
          db_cnt_q <= '0;
        end else if (flip_c) begin
          stable_q <= sync2[i];
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + CNT_W'(1);
        end
      end
    end

    assign btn.btn_level[i]   = stable_q;
    assign btn.btn_press[i]   = press_q;
    assign btn.btn_release[i] = release_q;

`ifdef BTN_REPEAT_EN
    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic             repeat_q;
    logic             repeat_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= RPT_IDLE;
        rpt_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        repeat_q  <= repeat_d;
      end
    end

    // Starts on the press edge; a release on any edge wins over a due repeat pulse.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          if (press_c) begin
            state_d   = RPT_DELAY;
            rpt_cnt_d = CNT_W'(1);
          end
        end
        RPT_DELAY: begin
          if (release_c) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == CNT_W'(REPEAT_DELAY)) begin
            state_d   = RPT_REPEAT;
            rpt_cnt_d = CNT_W'(1);
            repeat_d  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (release_c) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == CNT_W'(REPEAT_RATE)) begin
            rpt_cnt_d = CNT_W'(1);
            repeat_d  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = RPT_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end

    assign btn.btn_repeat[i] = repeat_q;
`else
    assign btn.btn_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed-vector bench for btn_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Repeat expectations follow whether BTN_REPEAT_EN is defined for the build.
module tb_btn_conditioner;

`ifdef BTN_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  btn_conditioner_if #(.NUM_BTN(4)) bif ();

  btn_conditioner #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .CNT_W          (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the press pulse on channel ch shows up (bounded).
  task automatic wait_press(input int ch, output int edges);
    edges = 0;
    while (bif.btn_press[ch] !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int e;
    int rep_cnt;
    logic exp_rep;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bif.btn_in = 4'b0000;
    repeat (3) tick();

    check("rst_level",   32'(bif.btn_level),   32'h0);
    check("rst_press",   32'(bif.btn_press),   32'h0);
    check("rst_release", 32'(bif.btn_release), 32'h0);
    check("rst_repeat",  32'(bif.btn_repeat),  32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Clean press and release on channel 0.
    bif.btn_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("p_level0_e%0d", k), 32'(bif.btn_level[0]), 32'(k >= 5));
      check($sformatf("p_press0_e%0d", k), 32'(bif.btn_press[0]), 32'(k == 5));
      check($sformatf("p_rel0_e%0d", k),   32'(bif.btn_release[0]), 32'h0);
      check($sformatf("p_others_e%0d", k), 32'({bif.btn_level[3:1], bif.btn_press[3:1]}), 32'h0);
    end
    bif.btn_in[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("r_level0_e%0d", k), 32'(bif.btn_level[0]), 32'(k < 5));
      check($sformatf("r_rel0_e%0d", k),   32'(bif.btn_release[0]), 32'(k == 5));
      check($sformatf("r_press0_e%0d", k), 32'(bif.btn_press[0]), 32'h0);
      check($sformatf("r_rep0_e%0d", k),   32'(bif.btn_repeat[0]), 32'h0);
    end

    // Glitch rejection on channel 1: 3 high, 1 low, 3 high, then low.
    begin
      logic [13:0] pat;
      pat = 14'b00000001110111;
      for (int k = 0; k < 14; k++) begin
        bif.btn_in[1] = pat[k];
        tick();
        check($sformatf("glitch1_c%0d", k),
              32'({bif.btn_level[1], bif.btn_press[1], bif.btn_release[1]}), 32'h0);
      end
    end

    // Auto-repeat then release priority on channel 2.
    bif.btn_in[2] = 1'b1;
    wait_press(2, e);
    check("press2_latency", 32'(e), 32'd6);
    rep_cnt = 0;
    for (int j = 1; j <= 50; j++) begin
      tick();
      exp_rep = RPT_EN && j >= 10 && j <= 40 && ((j - 10) % 3 == 0);
      rep_cnt += int'(bif.btn_repeat[2]);
      check($sformatf("rep2_p%0d", j),   32'(bif.btn_repeat[2]),  32'(exp_rep));
      check($sformatf("rel2_p%0d", j),   32'(bif.btn_release[2]), 32'(j == 43));
      check($sformatf("lvl2_p%0d", j),   32'(bif.btn_level[2]),   32'(j < 43));
      check($sformatf("press2_p%0d", j), 32'(bif.btn_press[2]),   32'h0);
      if (j == 37) bif.btn_in[2] = 1'b0;
    end
    check("rep2_total", 32'(rep_cnt), RPT_EN ? 32'd11 : 32'd0);

    // Async reset while channel 3 is held and repeating.
    bif.btn_in[3] = 1'b1;
    wait_press(3, e);
    check("press3_latency", 32'(e), 32'd6);
    repeat (12) tick();
    check("lvl3_before_rst", 32'(bif.btn_level[3]), 32'h1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_level",   32'(bif.btn_level),   32'h0);
    check("mid_rst_press",   32'(bif.btn_press),   32'h0);
    check("mid_rst_release", 32'(bif.btn_release), 32'h0);
    check("mid_rst_repeat",  32'(bif.btn_repeat),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tick();
      check($sformatf("post_rst_press3_e%0d", k), 32'(bif.btn_press[3]),  32'(k == 5));
      check($sformatf("post_rst_lvl3_e%0d", k),   32'(bif.btn_level[3]),  32'(k >= 5));
      check($sformatf("post_rst_rep3_e%0d", k),   32'(bif.btn_repeat[3]), 32'(RPT_EN && k == 15));
    end
    bif.btn_in[3] = 1'b0;
    repeat (8) tick();
    check("final_level", 32'(bif.btn_level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front end that turns the raw board buttons (move right, move left, shoot, continue) into clean, clk-synchronous control signals for the player and game-control blocks.
- Per button:
  - two-flop synchroniser;
  - counter-based debounce;
  - single-cycle press and release pulses;
  - optional auto-repeat pulses while the button is held.
- Sits between the top-level button pins and every consumer of button state.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the stable value before the stable value flips (10 ms at 100 MHz); legal minimum 2.
- REPEAT_DELAY, 30000000, cycles from the press pulse to the first repeat pulse; legal minimum 2.
- REPEAT_RATE, 10000000, cycles between subsequent repeat pulses; legal minimum 2.
- CNT_W, 32, width of all internal counters; must hold the largest of the three cycle counts.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; asynchronous, active-high.
- btn_in  in  NUM_BTN  raw button pins, asynchronous to clk, active-high.
- btn_level  out  NUM_BTN  debounced stable level.
- btn_press  out  NUM_BTN  one-cycle pulse on the debounced 0->1 transition.
- btn_release  out  NUM_BTN  one-cycle pulse on the debounced 1->0 transition.
- btn_repeat  out  NUM_BTN  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset (async assert, sampled deassert):
  - all outputs 0;
  - sync flops, stable values and counters 0;
  - all repeat FSMs in IDLE.
- Channels are fully independent; no cross-channel interaction.

Synchroniser:
- btn_in[i] -> s1 -> s2. The debouncer uses s2 only.

Debounce (per channel):
- When s2 == stable: debounce counter cleared to 0.
- When s2 != stable:
  - counter increments each cycle;
  - on the cycle the counter equals DEBOUNCE_CYCLES-1, stable <= s2 and counter <= 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles (measured at s2) resets the count and never changes stable.
- Latency: btn_in is sampled high at edge 0 and held. btn_level rises after edge 1+DEBOUNCE_CYCLES. Release latency is identical.

Pulses:
- btn_press / btn_release are registered on the same edge that updates btn_level.
- Each is high for exactly one cycle, coincident with the first cycle of the new btn_level value.
- Press and release can never be high together on one channel.

Repeat FSM (per channel):
- IDLE:
  - on the press pulse -> DELAY, repeat counter <= 1.
- DELAY:
  - counter increments each cycle;
  - when the counter equals REPEAT_DELAY: assert btn_repeat for one cycle, counter <= 1, -> REPEAT.
  - The first repeat pulse is therefore exactly REPEAT_DELAY cycles after the press pulse.
- REPEAT:
  - same counting;
  - pulse every REPEAT_RATE cycles, counter <= 1 after each pulse.
- In DELAY or REPEAT, a stable falling edge (release pulse cycle) forces IDLE and counter 0.
- No repeat pulse is emitted in or after the release cycle, even if the counter would have matched on that edge. Release has priority.
- btn_repeat never coincides with btn_press.
- Counters saturate only by construction (always cleared before CNT_W overflow when parameters are legal).

Reset mid-operation:
- Any state returns to the reset values immediately.
- A button held through reset deassertion produces a fresh press pulse after the normal debounce latency.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: the repeat FSMs and counters are built as described above.
- Undefined:
  - repeat logic is not synthesised;
  - btn_repeat is tied to 0;
  - REPEAT_DELAY and REPEAT_RATE are ignored.
- Debounce and press/release behaviour are identical in both builds.

Test Plan:
Bench parameters for all scenarios: NUM_BTN=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, BTN_REPEAT_EN defined.
1. Clean press:
   - Stimulus: btn_in[0] 0->1 sampled at edge 0, held.
   - Required: btn_level[0] rises after edge 5; btn_press[0] is high for exactly that one cycle; other channels stay 0.
2. Glitch rejection:
   - Stimulus: btn_in[1] high for 3 cycles, low for 1, high for 3, then low.
   - Required: btn_level[1], btn_press[1] and btn_release[1] never assert.
3. Auto-repeat:
   - Stimulus: hold btn_in[2] high for 40 cycles after the press pulse.
   - Required: btn_repeat[2] pulses at 10, 13, 16, ... cycles after the press pulse (11 pulses, the last at 40); each pulse is exactly one cycle wide.
4. Release priority:
   - Stimulus: release btn_in[2] so that the stable value falls on the same edge the counter would reach REPEAT_RATE.
   - Required: btn_release[2]=1, btn_repeat[2]=0 on that cycle and thereafter; the FSM is back in IDLE.
5. Async reset mid-hold:
   - Stimulus: assert rst for 2 cycles while btn_level[3]=1 and in REPEAT, with btn_in[3] still high.
   - Required: all outputs 0 immediately on rst; after deassertion, btn_press[3] reappears 6 edges later and btn_repeat[3] 10 cycles after that.
6. Build without the feature:
   - Stimulus: BTN_REPEAT_EN undefined, rerun scenario 3.
   - Required: btn_repeat stays 0; press/release timing matches scenario 1.
